// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle control unit: state codes, ALU control,
// datapath select codes, data-processing cmd opcodes and per-state control decode.
package mc_ctrl_fsm_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_t;

  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

  // ALUWB's RegW depends on the latched NoWrite and is patched in by the FSM.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    c.alu_src_b  = SRCB_RM;
    c.result_src = RES_ALUOUT;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
        c.next_pc    = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURES;
      end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_RDATA;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECR: c.alu_op = 1'b1;
      S_EXECI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURES;
        c.branch     = 1'b1;
      end
      default: c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-field inputs and control outputs of the multicycle control unit.
interface mc_ctrl_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       ir_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_control;
  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] flag_w;
  logic       pcs;

  modport master (
    input  op, funct, rd,
    output ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_control,
           next_pc, reg_w, mem_w, flag_w, pcs
  );

  modport slave (
    output op, funct, rd,
    input  ir_write, adr_src, alu_src_a, alu_src_b, result_src, alu_control,
           next_pc, reg_w, mem_w, flag_w, pcs
  );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU/flag decode: cmd + S bit + ALUOp -> ALUControl, FlagW, NoWrite.
module mc_alu_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic       alu_op,
  input  logic [3:0] cmd,
  input  logic       s_bit,
  output alu_ctrl_t  alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic known;
  logic s_eff;

  always_comb begin
    alu_control = ALU_ADD;
    known       = 1'b0;
    no_write    = 1'b0;
    s_eff       = s_bit;
    if (alu_op) begin
      known = 1'b1;
      case (cmd)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        CMD_CMP: begin
          alu_control = ALU_SUB;
          no_write    = 1'b1;
          s_eff       = 1'b1;
        end
        default: known = 1'b0;
      endcase
    end
    // C/V are only meaningful for the adder paths.
    flag_w[1] = known & s_eff;
    flag_w[0] = known & s_eff & ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM with registered Moore outputs; MC_CTRL_DBG_EN adds
// dbg_state and the dbg_retired instruction counter.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int STATE_W = STATE_BITS
) (
  input  logic               clk,
  input  logic               reset,
  mc_ctrl_fsm_if.master      bus
`ifdef MC_CTRL_DBG_EN
  ,
  output logic [STATE_W-1:0] dbg_state,
  output logic [31:0]        dbg_retired
`endif
);

  logic [STATE_W-1:0] state_q;
  state_t             cur;
  state_t             state_d;
  ctrl_t              ctrl_d;
  ctrl_t              ctrl_q;
  alu_ctrl_t          alu_control_d;
  alu_ctrl_t          alu_control_q;
  logic [1:0]         flag_w_d;
  logic [1:0]         flag_w_q;
  logic               no_write_d;
  logic               no_write_q;
`ifdef MC_CTRL_DBG_EN
  logic [31:0]        dbg_retired_q;
`endif

  assign cur = state_t'(state_q[STATE_BITS-1:0]);

  always_comb begin
    state_d = S_FETCH;
    case (cur)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
    // Outputs are decoded from the next state and registered, so they line up with state_q.
    ctrl_d = state_ctrl(state_d);
    if (state_d == S_ALUWB) begin
      ctrl_d.reg_w = ~no_write_q;
    end
  end

  mc_alu_decode u_alu_decode (
    .alu_op      (ctrl_d.alu_op),
    .cmd         (bus.funct[4:1]),
    .s_bit       (bus.funct[0]),
    .alu_control (alu_control_d),
    .flag_w      (flag_w_d),
    .no_write    (no_write_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= STATE_W'(S_FETCH);
      ctrl_q        <= state_ctrl(S_FETCH);
      alu_control_q <= ALU_ADD;
      flag_w_q      <= 2'b00;
      no_write_q    <= 1'b0;
`ifdef MC_CTRL_DBG_EN
      dbg_retired_q <= 32'd0;
`endif
    end else begin
      state_q       <= STATE_W'(state_d);
      ctrl_q        <= ctrl_d;
      alu_control_q <= alu_control_d;
      flag_w_q      <= flag_w_d;
      // NoWrite belongs to the instruction being decoded and must survive until ALUWB.
      if (cur == S_DECODE) begin
        no_write_q <= no_write_d;
      end
`ifdef MC_CTRL_DBG_EN
      if ((cur != S_FETCH) && (state_d == S_FETCH)) begin
        dbg_retired_q <= dbg_retired_q + 32'd1;
      end
`endif
    end
  end

  assign bus.ir_write    = ctrl_q.ir_write;
  assign bus.adr_src     = ctrl_q.adr_src;
  assign bus.alu_src_a   = ctrl_q.alu_src_a;
  assign bus.alu_src_b   = ctrl_q.alu_src_b;
  assign bus.result_src  = ctrl_q.result_src;
  assign bus.alu_control = alu_control_q;
  assign bus.next_pc     = ctrl_q.next_pc;
  assign bus.reg_w       = ctrl_q.reg_w;
  assign bus.mem_w       = ctrl_q.mem_w;
  assign bus.flag_w      = flag_w_q;
  assign bus.pcs         = ctrl_q.branch | (ctrl_q.reg_w & (bus.rd == 4'd15));

`ifdef MC_CTRL_DBG_EN
  assign dbg_state   = state_q;
  assign dbg_retired = dbg_retired_q;
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit: main state machine plus ALU/flag decode.
- Produces the raw per-instruction control toward condition logic: FlagW, PCS, RegW, MemW, NextPC.
- Also drives datapath mux selects and ALU control.
- Sits between instruction register fields (Op, Funct, Rd) and the condition-logic/datapath; condition gating (CondEx) is applied downstream, not here.

Parameters:
- STATE_W, 4, state register width (10 states used).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Op  input  2  instr[27:26]
- Funct  input  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
- Rd  input  4  instr[15:12]
- IRWrite  output  1  instruction register load
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- ALUSrcA  output  1  0=Rn, 1=PC
- ALUSrcB  output  2  00=Rm, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- NextPC  output  1  PC write request, unconditional
- RegW  output  1  register write request, pre-CondEx
- MemW  output  1  memory write request, pre-CondEx
- FlagW  output  2  [1]=NZ write, [0]=CV write, pre-CondEx
- PCS  output  1  PC-source request: Branch | (Rd==15 & RegW)

Behaviour:
- Reset:
  - reset high at a clk edge → state=FETCH.
  - Outputs are Moore-decoded from state, so the cycle after reset shows FETCH values.
  - Reset mid-instruction abandons it; no write strobes are asserted in the following cycle except FETCH's IRWrite/NextPC.
- States FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; default state → FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - Op=01 → MEMADR.
    - Op=00 with Funct[5]=0 → EXECR; with Funct[5]=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11 → FETCH (no side effects).
  - MEMADR: Funct[0]=1 → MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH; MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
- Outputs by state (unlisted = 0):
  - FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1, AdrSrc=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1 unless NoWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode, active only when ALUOp=1:
  - cmd 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1010 (CMP)→SUB with NoWrite=1.
  - Other cmd → ADD, no flags.
  - ALUOp=0 → ALUControl=ADD.
- FlagW: nonzero only in EXECR/EXECI.
  - FlagW[1]=S; FlagW[0]=S & (ALUControl is ADD or SUB).
  - CMP forces S=1.
- NoWrite is registered with the instruction's DECODE and held through ALUWB.
- PCS: combinational from Branch, RegW, Rd, so it asserts in BRANCH, and in MEMWB/ALUWB when Rd=15.
- Latency: load 5 cycles, store 4, data-processing 4, branch 3, Op=11 2.
- No output depends combinationally on CondEx.

Optional Feature:
- Macro MC_CTRL_DBG_EN.
- Defined: adds output dbg_state [STATE_W-1:0], equal to the state register encoding, plus a 32-bit retired-instruction counter dbg_retired.
  - Counter increments on every transition into FETCH from a non-FETCH state and clears on reset.
- Undefined: neither port exists; the rest of the behaviour is identical.

Decomposition:
- Shared package: state encoding constants, ALUControl codes, ALUSrcB/ResultSrc select codes, cmd opcodes.
- Natural sub-module: mc_alu_decode, a combinational Funct+ALUOp → ALUControl, FlagW, NoWrite block. The FSM instantiates it.

Test Plan:
- Reset held 2 cycles, release → cycle 1 shows IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10; cycle 2 shows DECODE values.
- LDR: Op=01, Funct=011001, Rd=3 → FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegW=1 only in MEMWB, PCS=0, MemW never 1.
- STR: Op=01, Funct=011000 → MemW=1 exactly in cycle 4, AdrSrc=1, then FETCH.
- SUBS: Op=00, Funct=000101 (cmd 0010, S=1) → EXECR with ALUControl=01, FlagW=11; ALUWB with RegW=1.
- CMP imm: Op=00, Funct=110101 → EXECI with FlagW=11, ALUControl=01; ALUWB with RegW=0.
- Branch: Op=10 → BRANCH with PCS=1, ALUSrcB=01. ADD to Rd=15 (Funct=001000) → ALUWB with PCS=1, FlagW=00. Reset asserted in MEMWR → next cycle FETCH, MemW=0.
